// File: rtl/ps2_kbd_pad.sv
`default_nettype none
// ============================================================================
// Module      : ps2_kbd_pad
// Description : PS/2 keyboard receiver. Deserialises 11-bit frames, decodes
//               E0/F0 prefixes into make/break events and keeps an 8-bit
//               held-key vector laid out like a joystick pad byte.
// Revision    : 1.0 - initial release
// ============================================================================
module ps2_kbd_pad #(
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       key_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_released,
    output logic       frame_err,
    output logic [7:0] pad
);

    localparam logic [15:0] C_TICK = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_RESYNC = 3'd0,
        S_IDLE   = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_clk_s1, r_clk_s2, r_clk_prev;
    logic        r_dat_s1, r_dat_s2;
    logic        w_fall;
    logic        w_tick;
    logic [15:0] r_cnt;
    logic [2:0]  r_bit_cnt;
    logic [7:0]  r_shift;
    logic        r_par_err;
    logic        r_ext, r_rel;
    logic        w_err, w_done;
    logic [7:0]  w_pad_hit;

    // Two-flop synchronisers plus one extra clock stage for edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            r_clk_s1   <= 1'b0;
            r_clk_s2   <= 1'b0;
            r_clk_prev <= 1'b0;
            r_dat_s1   <= 1'b0;
            r_dat_s2   <= 1'b0;
        end else begin
            r_clk_s1   <= ps2_clk_in;
            r_clk_s2   <= r_clk_s1;
            r_clk_prev <= r_clk_s2;
            r_dat_s1   <= ps2_data_in;
            r_dat_s2   <= r_dat_s1;
        end
    end

    assign w_fall = r_clk_prev & ~r_clk_s2;
    assign w_tick = (r_cnt == C_TICK);

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= S_RESYNC;
        else       r_state <= w_next;
    end

    // Next-state logic; a frame error or completed byte is flagged here
    always_comb begin
        w_next = r_state;
        w_err  = 1'b0;
        w_done = 1'b0;
        case (r_state)
            S_RESYNC: begin
                if (r_clk_s2 && w_tick) w_next = S_IDLE;
            end
            S_IDLE: begin
                if (w_fall) begin
                    if (!r_dat_s2) begin
                        w_next = S_DATA;
                    end else begin
                        w_err  = 1'b1;
                        w_next = S_RESYNC;
                    end
                end
            end
            S_DATA, S_PARITY, S_STOP: begin
                if (w_fall) begin
                    if (r_state == S_DATA) begin
                        if (r_bit_cnt == 3'd7) w_next = S_PARITY;
                    end else if (r_state == S_PARITY) begin
                        w_next = S_STOP;
                    end else if (r_dat_s2 && !r_par_err) begin
                        w_done = 1'b1;
                        w_next = S_IDLE;
                    end else begin
                        w_err  = 1'b1;
                        w_next = S_RESYNC;
                    end
                end else if (w_tick) begin
                    w_err  = 1'b1;
                    w_next = S_RESYNC;
                end
            end
            default: w_next = S_RESYNC;
        endcase
    end

    // Shared counter: idle-high time in RESYNC, edge-to-edge time inside a frame
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if ((w_next != r_state) || w_fall || (r_state == S_IDLE) ||
                     ((r_state == S_RESYNC) && !r_clk_s2)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 16'd1;
        end
    end

    // Shift register, bit counter and parity check
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par_err <= 1'b0;
        end else if (w_fall) begin
            if (r_state == S_IDLE) begin
                r_bit_cnt <= '0;
                r_par_err <= 1'b0;
            end else if (r_state == S_DATA) begin
                r_shift   <= {r_dat_s2, r_shift[7:1]};
                r_bit_cnt <= r_bit_cnt + 3'd1;
            end else if (r_state == S_PARITY) begin
                r_par_err <= ~(^{r_shift, r_dat_s2});
            end
        end
    end

    // Pad bits touched by the byte currently being decoded
    always_comb begin
        w_pad_hit    = '0;
        w_pad_hit[0] = r_ext  && (r_shift == 8'h74);
        w_pad_hit[1] = r_ext  && (r_shift == 8'h6B);
        w_pad_hit[2] = r_ext  && (r_shift == 8'h72);
        w_pad_hit[3] = r_ext  && (r_shift == 8'h75);
        w_pad_hit[4] = !r_ext && (r_shift == 8'h1C);
        w_pad_hit[5] = !r_ext && (r_shift == 8'h1B);
        w_pad_hit[6] = !r_ext && (r_shift == 8'h23);
        w_pad_hit[7] = (r_shift == 8'h5A);
    end

    // Prefix tracking, event outputs and held-key vector
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ext        <= 1'b0;
            r_rel        <= 1'b0;
            key_valid    <= 1'b0;
            key_code     <= '0;
            key_ext      <= 1'b0;
            key_released <= 1'b0;
            frame_err    <= 1'b0;
            pad          <= '0;
        end else begin
            key_valid <= 1'b0;
            frame_err <= w_err;
            if (w_err) begin
                r_ext <= 1'b0;
                r_rel <= 1'b0;
            end else if (w_done) begin
                case (r_shift)
                    8'hE0: r_ext <= 1'b1;
                    8'hF0: r_rel <= 1'b1;
                    8'hE1: begin
                    end
                    8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: begin
                        r_ext <= 1'b0;
                        r_rel <= 1'b0;
                    end
                    default: begin
                        key_valid    <= 1'b1;
                        key_code     <= r_shift;
                        key_ext      <= r_ext;
                        key_released <= r_rel;
                        r_ext        <= 1'b0;
                        r_rel        <= 1'b0;
                        pad          <= r_rel ? (pad & ~w_pad_hit) : (pad | w_pad_hit);
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire
